// File: rtl/vchk_pkg.sv
// Shared types and helpers for the vector checker.
// VEC_W depends on VCHK_MASK_EN: the mask field exists only when the macro is defined.
package vchk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} vchk_state_t;

    // Store word layout, MSB first: {valid, stim, exp[, mask]}
    function automatic int vecW(input int stimW, input int expW);
`ifdef VCHK_MASK_EN
        return 1 + stimW + 2 * expW;
`else
        return 1 + stimW + expW;
`endif
    endfunction

endpackage

// File: rtl/vchk_delay.sv
// Check-tag delay line: a valid shift register plus payload stages.
// Valid bits clear synchronously on clr; LATENCY==0 is a plain wire-through.
module vchk_delay #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             vldIn,
    input  logic [WIDTH-1:0] din,
    output logic             vldOut,
    output logic [WIDTH-1:0] dout
);

    generate
        if (LATENCY == 0) begin : gThru
            logic unusedCtl;
            assign unusedCtl = clk ^ clr;
            assign vldOut    = vldIn;
            assign dout      = din;
        end else begin : gPipe
            logic [LATENCY:1] vldPipe;
            logic [WIDTH-1:0] dataPipe [1:LATENCY];

            always_ff @(posedge clk) begin
                if (clr) begin
                    vldPipe <= '0;
                end else begin
                    vldPipe[1] <= vldIn;
                    for (int i = 2; i <= LATENCY; i++)
                        vldPipe[i] <= vldPipe[i-1];
                end
            end

            // Payload only matters where the matching valid bit is set, so no clear
            always_ff @(posedge clk) begin
                dataPipe[1] <= din;
                for (int i = 2; i <= LATENCY; i++)
                    dataPipe[i] <= dataPipe[i-1];
            end

            assign vldOut = vldPipe[LATENCY];
            assign dout   = dataPipe[LATENCY];
        end
    endgenerate

endmodule

// File: rtl/vector_checker.sv
// Stimulus/response engine: applies stored vectors and checks DUT responses LATENCY cycles later.
// Define VCHK_MASK_EN to add a per-vector compare mask (mask bit 0 = don't care).
module vector_checker
    import vchk_pkg::*;
#(
    parameter int  STIM_W  = 32,
    parameter int  EXP_W   = 32,
    parameter int  DEPTH   = 64,
    parameter int  LATENCY = 1,
    parameter int  CNT_W   = 16,
    localparam int AW      = $clog2(DEPTH),
    localparam int VEC_W   = vecW(STIM_W, EXP_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [VEC_W-1:0]  ld_data,
    input  logic              start,
    output logic [STIM_W-1:0] stim_o,
    input  logic [EXP_W-1:0]  dut_i,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  vec_cnt,
    output logic [AW-1:0]     first_fail
);

    if (DEPTH >= (1 << CNT_W)) begin : gCntChk
        $error("vector_checker: DEPTH must be below 2**CNT_W");
    end
    if ((1 << AW) != DEPTH) begin : gDepthChk
        $error("vector_checker: DEPTH must be a power of 2");
    end
    if (LATENCY < 0 || LATENCY > 15) begin : gLatChk
        $error("vector_checker: LATENCY must be 0..15");
    end

    typedef struct packed {
        logic              valid;
        logic [STIM_W-1:0] stim;
        logic [EXP_W-1:0]  exp;
`ifdef VCHK_MASK_EN
        logic [EXP_W-1:0]  mask;
`endif
    } vec_t;

    typedef struct packed {
        logic             valid;
        logic [EXP_W-1:0] exp;
        logic [EXP_W-1:0] mask;
        logic [AW-1:0]    idx;
    } chk_tag_t;

    localparam int TAG_W  = $bits(chk_tag_t) - 1;
    localparam int LAT_M1 = (LATENCY > 0) ? LATENCY - 1 : 0;

    vchk_state_t       state, stateNext;
    vec_t              mem [DEPTH];
    vec_t              cur;
    logic              nxtValid;
    logic [AW-1:0]     idx, idxNext;
    logic [EXP_W-1:0]  curMask;
    logic [3:0]        drainCnt;
    logic              apply, clrRun;
    logic [STIM_W-1:0] stimReg;
    chk_tag_t          tagIn, head;
    logic              headVld;
    logic [TAG_W-1:0]  headData;
    logic              mismatch;
    logic [CNT_W-1:0]  vecNext, errNext;
    logic [AW-1:0]     ffNext;

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    // Vector store: writes are only accepted while idle or done
    always_ff @(posedge clk) begin
        if (!reset && ld_en && !busy)
            mem[ld_addr] <= vec_t'(ld_data);
    end

    assign idxNext  = idx + AW'(1);
    assign cur      = mem[idx];
    assign nxtValid = mem[idxNext].valid;

`ifdef VCHK_MASK_EN
    assign curMask = cur.mask;
`else
    assign curMask = '1;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Run ends on the cycle that applies the last vector by looking one entry ahead
    always_comb begin
        stateNext = state;
        apply     = 1'b0;
        clrRun    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext = RUN;
                    clrRun    = 1'b1;
                end
            end
            RUN: begin
                if (!cur.valid) begin
                    stateNext = (LATENCY == 0) ? DONE : DRAIN;
                end else begin
                    apply = 1'b1;
                    if (idx == AW'(DEPTH - 1) || !nxtValid)
                        stateNext = (LATENCY == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drainCnt == 4'(LAT_M1))
                    stateNext = DONE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state != DRAIN) drainCnt <= '0;
        else                         drainCnt <= drainCnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            stimReg <= '0;
        end else begin
            if (clrRun)     idx <= '0;
            else if (apply) idx <= idxNext;
            if (apply)      stimReg <= cur.stim;
        end
    end

    // Zero-latency mode drives the stimulus straight from the store
    generate
        if (LATENCY == 0) begin : gStimComb
            assign stim_o = apply ? cur.stim : stimReg;
        end else begin : gStimReg
            assign stim_o = stimReg;
        end
    endgenerate

    assign tagIn = '{valid: apply, exp: cur.exp, mask: curMask, idx: idx};

    vchk_delay #(
        .WIDTH   (TAG_W),
        .LATENCY (LATENCY)
    ) uDelay (
        .clk    (clk),
        .clr    (reset || clrRun),
        .vldIn  (tagIn.valid),
        .din    (tagIn[TAG_W-1:0]),
        .vldOut (headVld),
        .dout   (headData)
    );

    assign head     = {headVld, headData};
    assign mismatch = |((dut_i ^ head.exp) & head.mask);

    always_comb begin
        vecNext = vec_cnt;
        errNext = err_cnt;
        ffNext  = first_fail;
        if (clrRun) begin
            vecNext = '0;
            errNext = '0;
            ffNext  = '0;
        end else if (head.valid) begin
            vecNext = vec_cnt + 1'b1;
            if (mismatch) begin
                if (err_cnt != '1) errNext = err_cnt + 1'b1;
                // err_cnt saturates and never returns to zero, so this marks the first miss
                if (err_cnt == '0) ffNext = head.idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vec_cnt    <= '0;
            err_cnt    <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else begin
            vec_cnt    <= vecNext;
            err_cnt    <= errNext;
            first_fail <= ffNext;
            pass       <= (stateNext == DONE) && (errNext == '0) && (vecNext != '0);
        end
    end

endmodule
